ps2_controller: RTL and testbench

PS/2 keyboard receiver that deserialises 11-bit device-to-host frames clocked by the keyboard's own PS2_CLK. It tracks the break (0xF0) prefix and presents the current key scan code on `data_out`. `data_out` reads 0x00 once the key is released. It sits between the PS/2 connector pins and the keypress-consuming logic.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_controller_if.sv | 8 +
 rtl/ps2_frame_rx.sv | 66 ++++++
 rtl/ps2_controller.sv | 51 +++++
 tb/tb_ps2_controller.sv | 106 ++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int unsigned PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_controller_if.sv
// Received-byte stream from the frame deserialiser to the key tracker.
interface ps2_controller_if;
  logic       byte_valid;
  logic [7:0] rx_byte;

  modport master (output byte_valid, output rx_byte);
  modport slave  (input  byte_valid, input  rx_byte);
endinterface

// File: rtl/ps2_frame_rx.sv
// Deserialises one 11-bit PS/2 frame; pulses byte_valid on the stop-bit edge
// of a frame with odd parity and a high stop bit.
module ps2_frame_rx
  import ps2_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ps2_dat_i,
  ps2_controller_if.master    rx
);

  ps2_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    rx.byte_valid = 1'b0;
    rx.rx_byte    = shift_q;
    unique case (state_q)
      IDLE: begin
        if (!ps2_dat_i) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d[cnt_q] = ps2_dat_i;
        if (cnt_q == 3'(PS2_DATA_BITS - 1)) begin
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      PARITY: begin
        par_d   = ps2_dat_i;
        state_d = STOP;
      end
      STOP: begin
        // Combinational so the consumer can register the byte on this same edge.
        rx.byte_valid = ps2_dat_i & (^{shift_q, par_q});
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_controller.sv
// PS/2 keyboard receiver: shows the held key's scan code, 0x00 after its break sequence.
module ps2_controller
  import ps2_pkg::*;
(
  input  logic       PS2_CLK,
  input  logic       rst,
  input  logic       PS2_DAT,
  output logic [7:0] data_out
);

  ps2_controller_if rx_bus ();

  ps2_frame_rx u_frame_rx (
    .clk_i     (PS2_CLK),
    .rst_ni    (rst),
    .ps2_dat_i (PS2_DAT),
    .rx        (rx_bus.master)
  );

  logic       brk_q, brk_d;
  logic [7:0] data_q, data_d;

  always_ff @(negedge PS2_CLK or negedge rst) begin
    if (!rst) begin
      brk_q  <= 1'b0;
      data_q <= '0;
    end else begin
      brk_q  <= brk_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    brk_d  = brk_q;
    data_d = data_q;
    if (rx_bus.byte_valid) begin
      if (rx_bus.rx_byte == PS2_BREAK_CODE) begin
        brk_d  = 1'b1;
        data_d = PS2_BREAK_CODE;
      end else if (brk_q) begin
        brk_d  = 1'b0;
        data_d = '0;
      end else begin
        data_d = rx_bus.rx_byte;
      end
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_ps2_controller.sv
// Directed bench for ps2_controller: drives PS/2 frames bit by bit and checks data_out.
`timescale 1ns/1ps
module tb_ps2_controller;

  logic       PS2_CLK;
  logic       rst;
  logic       PS2_DAT;
  logic [7:0] data_out;

  int unsigned tests;
  int unsigned fails;

  localparam int unsigned HALF = 20000; // 40 us period, 25 kHz-ish bench clock

  ps2_controller dut (
    .PS2_CLK  (PS2_CLK),
    .rst      (rst),
    .PS2_DAT  (PS2_DAT),
    .data_out (data_out)
  );

  task automatic check(input string tag, input logic [7:0] exp);
    tests++;
    assert (data_out === exp)
      else begin
        fails++;
        $error("FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
      end
  endtask

  // One bit: set data while clock is high, falling edge, sample point, rising edge.
  task automatic send_bit(input logic v);
    PS2_DAT = v;
    #HALF PS2_CLK = 1'b0;
    #HALF PS2_CLK = 1'b1;
  endtask

  // Full frame; checks data_out is unchanged before the stop edge and equals
  // exp right after it.
  task automatic send_frame(input string tag, input logic [7:0] b,
                            input logic par_ok, input logic stop,
                            input logic [7:0] prev, input logic [7:0] exp);
    logic par;
    par = par_ok ? ~(^b) : (^b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    check({tag, "_prestop"}, prev);
    PS2_DAT = stop;
    #HALF PS2_CLK = 1'b0;
    #1000;
    check(tag, exp);
    #(HALF - 1000) PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    #HALF;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    rst     = 1'b0;

    #5000;
    check("reset_no_clk", 8'h00);
    rst = 1'b1;
    #HALF;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    #20000;
    check("idle_high", 8'h00);

    send_frame("press_15",       8'h15, 1'b1, 1'b1, 8'h00, 8'h15);
    send_frame("break_f0",       8'hF0, 1'b1, 1'b1, 8'h15, 8'hF0);
    send_frame("break_f0_again", 8'hF0, 1'b1, 1'b1, 8'hF0, 8'hF0);
    send_frame("release_15",     8'h15, 1'b1, 1'b1, 8'hF0, 8'h00);
    send_frame("press_15_b",     8'h15, 1'b1, 1'b1, 8'h00, 8'h15);
    send_frame("bad_parity_1c",  8'h1C, 1'b0, 1'b1, 8'h15, 8'h15);
    send_frame("press_1c",       8'h1C, 1'b1, 1'b1, 8'h15, 8'h1C);
    send_frame("bad_stop_15",    8'h15, 1'b1, 1'b0, 8'h1C, 8'h1C);
    send_frame("after_bad_stop", 8'h15, 1'b1, 1'b1, 8'h1C, 8'h15);
    send_frame("prefix_e0",      8'hE0, 1'b1, 1'b1, 8'h15, 8'hE0);
    send_frame("break_f0_b",     8'hF0, 1'b1, 1'b1, 8'hE0, 8'hF0);
    send_frame("brk_bad_par",    8'h1C, 1'b0, 1'b1, 8'hF0, 8'hF0);
    send_frame("release_1c",     8'h1C, 1'b1, 1'b1, 8'hF0, 8'h00);
    send_frame("press_5a",       8'h5A, 1'b1, 1'b1, 8'h00, 8'h5A);

    // Abort a frame after four data bits with reset.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    #1000;
    check("midframe_reset", 8'h00);
    #1000 rst = 1'b1;
    PS2_DAT = 1'b1;
    #HALF;
    send_frame("post_reset_15",  8'h15, 1'b1, 1'b1, 8'h00, 8'h15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
